// File: rtl/isa_shared.sv
// isa_shared: RV32I opcode and sign-extension selector constants shared by
// the decode stage, plus the decoded output bundle.
`default_nettype none

package isa_shared;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [2:0] SX_NONE = 3'b000;
   localparam logic [2:0] SX_1100 = 3'b001;
   localparam logic [2:0] SX_3100 = 3'b010;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [6:0]       opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [XLEN-1:0]  unextended;
      logic [2:0]       sx_op;
      logic             illegal;
   } decoded_t;

endpackage

`default_nettype wire

// File: rtl/instr_decode_stage_imm_assemble.sv
// imm_assemble: combinational raw-immediate extraction and signext selector
// for one RV32I instruction.
`default_nettype none

module imm_assemble
   import isa_shared::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] unextended_data,
   output logic [2:0]            sx_op,
   output logic                  illegal
);

   always_comb begin
      unextended_data = '0;
      sx_op           = SX_NONE;
      illegal         = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR: begin
            unextended_data = {{(DATA_WIDTH-12){1'b0}}, instr[31:20]};
            sx_op           = SX_1100;
         end
         OP_STORE: begin
            unextended_data = {{(DATA_WIDTH-12){1'b0}}, instr[31:25], instr[11:7]};
            sx_op           = SX_1100;
         end
         OP_LUI, OP_AUIPC: begin
            unextended_data = {instr[31:12], {(DATA_WIDTH-20){1'b0}}};
            sx_op           = SX_3100;
         end
         // Branch and jump offsets are scrambled, so they are sign-extended
         // here and signext only passes them through.
         OP_BRANCH: begin
            unextended_data = {{(DATA_WIDTH-12){instr[31]}}, instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            sx_op           = SX_3100;
         end
         OP_JAL: begin
            unextended_data = {{(DATA_WIDTH-20){instr[31]}}, instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            sx_op           = SX_3100;
         end
         OP_OP: begin
            unextended_data = '0;
            sx_op           = SX_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: 2-entry skid-buffered RV32I decode stage producing
// register fields, raw immediate and signext selector.
`default_nettype none

module instr_decode_stage
   import isa_shared::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic [DATA_WIDTH-1:0] in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [6:0]            out_opcode,
   output logic [2:0]            out_funct3,
   output logic [6:0]            out_funct7,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [REG_ADDR_W-1:0] out_rs1,
   output logic [REG_ADDR_W-1:0] out_rs2,
   output logic [DATA_WIDTH-1:0] unextended_data,
   output logic [2:0]            sx_op,
   output logic                  out_illegal
);

   logic [DATA_WIDTH-1:0] main_instr;
   logic [DATA_WIDTH-1:0] main_pc;
   logic                  main_valid;
   logic [DATA_WIDTH-1:0] skid_instr;
   logic [DATA_WIDTH-1:0] skid_pc;
   logic                  skid_valid;

   logic                  in_xfer;
   logic [DATA_WIDTH-1:0] imm_raw;
   logic [2:0]            imm_sx;
   logic                  imm_illegal;
   decoded_t              dec;

   assign in_ready = !skid_valid;
   assign in_xfer  = in_valid && !skid_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_instr <= '0;
         main_pc    <= '0;
         main_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid) begin
         if (in_xfer) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_valid <= 1'b1;
         end
      end else if (skid_valid) begin
         if (out_ready) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            skid_valid <= 1'b0;
         end
      end else begin
         if (in_xfer && out_ready) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
         end else if (in_xfer) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_valid <= 1'b1;
         end else if (out_ready) begin
            main_valid <= 1'b0;
         end
      end
   end

   imm_assemble #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_imm_assemble (
      .instr           (main_instr),
      .unextended_data (imm_raw),
      .sx_op           (imm_sx),
      .illegal         (imm_illegal)
   );

   // Outputs are forced to zero whenever main is empty so stale or reset
   // contents never look like a decoded (or illegal) instruction.
   always_comb begin
      dec       = '0;
      dec.sx_op = SX_NONE;
      if (main_valid) begin
         dec.pc         = main_pc;
         dec.opcode     = main_instr[6:0];
         dec.funct3     = main_instr[14:12];
         dec.funct7     = main_instr[31:25];
         dec.rd         = main_instr[11:7];
         dec.rs1        = main_instr[19:15];
         dec.rs2        = main_instr[24:20];
         dec.unextended = imm_raw;
         dec.sx_op      = imm_sx;
         dec.illegal    = imm_illegal;
      end
   end

   assign out_valid       = main_valid;
   assign out_pc          = dec.pc;
   assign out_opcode      = dec.opcode;
   assign out_funct3      = dec.funct3;
   assign out_funct7      = dec.funct7;
   assign out_rd          = dec.rd;
   assign out_rs1         = dec.rs1;
   assign out_rs2         = dec.rs2;
   assign unextended_data = dec.unextended;
   assign sx_op           = dec.sx_op;
   assign out_illegal     = dec.illegal;

endmodule

`default_nettype wire
